// File: rtl/pwm_mejorado_if.sv
// Control/output bundle of the PWM generator: duty request and prescaler
// terminal count in, registered PWM waveform out.
interface pwm_mejorado_if #(
  parameter int R          = 8,
  parameter int TIMER_BITS = 8
);
  logic [R:0]            ciclo;
  logic [TIMER_BITS-1:0] FINAL_VALUE;
  logic                  pwm_out;

  modport master (
    output ciclo,
    output FINAL_VALUE,
    input  pwm_out
  );

  modport slave (
    input  ciclo,
    input  FINAL_VALUE,
    output pwm_out
  );
endinterface

// File: rtl/pwm_mejorado.sv
// PWM generator: prescaled tick drives an R-bit duty counter; the duty value
// is latched once per period so requests never glitch the current period.
module pwm_mejorado #(
  parameter int R          = 8,
  parameter int TIMER_BITS = 8
) (
  input logic            clk,
  input logic            reset,
  pwm_mejorado_if.slave  bus
);

  localparam logic [R:0]            DUTY_FULL = {1'b1, {R{1'b0}}};
  localparam logic [TIMER_BITS-1:0] TIMER_ONE = {{(TIMER_BITS-1){1'b0}}, 1'b1};
  localparam logic [R-1:0]          Q_ONE     = {{(R-1){1'b0}}, 1'b1};

  logic [TIMER_BITS-1:0] r_timer_p0;
  logic [R-1:0]          r_q_p0;
  logic [R:0]            r_d_p0;
  logic                  r_pwm_p1;

  logic                  w_tick_p0;
  logic                  w_start_p0;
  logic                  w_high_p0;

  function automatic logic [R:0] sat_duty(input logic [R:0] req);
    return (req > DUTY_FULL) ? DUTY_FULL : req;
  endfunction

  // Stage p0: prescaler, duty counter and period-start duty latch.
  // ">=" lets a lowered terminal count end the tick at once instead of wrapping.
  assign w_tick_p0  = (r_timer_p0 >= bus.FINAL_VALUE);
  assign w_start_p0 = (r_timer_p0 == '0) && (r_q_p0 == '0);
  assign w_high_p0  = ({1'b0, r_q_p0} < r_d_p0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer_p0 <= '0;
      r_q_p0     <= '0;
      r_d_p0     <= '0;
    end else begin
      if (w_tick_p0) begin
        r_timer_p0 <= '0;
        r_q_p0     <= r_q_p0 + Q_ONE;
      end else begin
        r_timer_p0 <= r_timer_p0 + TIMER_ONE;
      end
      if (w_start_p0) begin
        r_d_p0 <= sat_duty(bus.ciclo);
      end
    end
  end

  // Stage p1: registered compare of the pre-edge counter against the latched duty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwm_p1 <= 1'b0;
    end else begin
      r_pwm_p1 <= w_high_p0;
    end
  end

  assign bus.pwm_out = r_pwm_p1;

endmodule

// File: tb/tb_pwm_mejorado.sv
// Bench for pwm_mejorado: table of steady-state duty measurements, hand-built
// corner sequences, and randomized runs against a closed-form timing model.
module tb_pwm_mejorado;

  localparam int R  = 8;
  localparam int TW = 8;
  localparam int NQ = 1 << R;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pwm_mejorado_if #(.R(R), .TIMER_BITS(TW)) bus ();

  pwm_mejorado #(.R(R), .TIMER_BITS(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int fv;
    int c;
    int exp_hi;
    int exp_per;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int sat(input int c);
    return (c > NQ) ? NQ : c;
  endfunction

  // Reset is released at a falling edge, so the next rising edge is edge 1.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_pwm_low", int'(bus.pwm_out), 0);
    reset = 1'b0;
  endtask

  // Closed-form model: after edge k, Q = floor(k/(FV+1)) mod 2^R; D is
  // reloaded at edges k where k-1 is a multiple of the period P; output after
  // edge n is (Q,D) after edge n-1 compared.
  task automatic run_model(input int fv, input int start_c, input int ncyc,
                           input int chg_div, input string tag);
    int p, dcur, qprev, exp_v, bad;
    bus.FINAL_VALUE = TW'(fv);
    bus.ciclo       = (R+1)'(start_c);
    do_reset();
    p    = NQ * (fv + 1);
    dcur = 0;
    bad  = 0;
    for (int n = 1; n <= ncyc && bad == 0; n++) begin
      @(posedge clk);
      qprev = ((n - 1) / (fv + 1)) % NQ;
      exp_v = (qprev < dcur) ? 1 : 0;
      if (((n - 1) % p) == 0) dcur = sat(int'(bus.ciclo));
      #1;
      if (int'(bus.pwm_out) !== exp_v) bad = 1;
      check($sformatf("%s_fv%0d_edge%0d", tag, fv, n), int'(bus.pwm_out), exp_v);
      if (chg_div > 0 && $urandom_range(chg_div - 1, 0) == 0)
        bus.ciclo = (R+1)'($urandom_range(300, 0));
    end
  endtask

  task automatic measure(input int fv, input int c, output int hi, output int per);
    int p, prev, r1, r2, nrise, s;
    bus.FINAL_VALUE = TW'(fv);
    bus.ciclo       = (R+1)'(c);
    do_reset();
    p = NQ * (fv + 1);
    @(posedge clk);
    repeat (p) @(posedge clk);
    #1 prev = int'(bus.pwm_out);
    hi = 0; nrise = 0; r1 = 0; r2 = 0;
    for (int i = 0; i < 2 * p; i++) begin
      @(posedge clk);
      #1 s = int'(bus.pwm_out);
      if (i < p && s == 1) hi++;
      if (prev == 0 && s == 1) begin
        if (nrise == 0) r1 = i;
        else if (nrise == 1) r2 = i;
        nrise++;
      end
      prev = s;
    end
    per = (nrise >= 2) ? (r2 - r1) : 0;
  endtask

  task automatic count_window(input int n, input int chg_at, input int chg_val,
                              output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.pwm_out === 1'b1) hi++;
      if (i == chg_at) bus.ciclo = (R+1)'(chg_val);
    end
  endtask

  initial begin
    int hi, per, p;
    bus.ciclo       = '0;
    bus.FINAL_VALUE = '0;

    #2 check("pwm_low_in_reset", int'(bus.pwm_out), 0);

    tbl[0] = '{fv: 2, c: 64,  exp_hi: 192, exp_per: 768};
    tbl[1] = '{fv: 2, c: 128, exp_hi: 384, exp_per: 768};
    tbl[2] = '{fv: 2, c: 192, exp_hi: 576, exp_per: 768};
    tbl[3] = '{fv: 0, c: 3,   exp_hi: 3,   exp_per: 256};
    tbl[4] = '{fv: 2, c: 0,   exp_hi: 0,   exp_per: 0};
    tbl[5] = '{fv: 2, c: 256, exp_hi: 768, exp_per: 0};
    tbl[6] = '{fv: 2, c: 300, exp_hi: 768, exp_per: 0};
    tbl[7] = '{fv: 1, c: 1,   exp_hi: 2,   exp_per: 512};

    for (int k = 0; k < 8; k++) begin
      measure(tbl[k].fv, tbl[k].c, hi, per);
      check($sformatf("vec%0d_high_clocks", k), hi, tbl[k].exp_hi);
      check($sformatf("vec%0d_period", k), per, tbl[k].exp_per);
    end

    // First output edges after reset: D loads on edge 1, output follows on edge 2.
    bus.FINAL_VALUE = 8'd2;
    bus.ciclo       = 9'd64;
    do_reset();
    @(posedge clk); #1 check("edge1_still_low", int'(bus.pwm_out), 0);
    @(posedge clk); #1 check("edge2_high", int'(bus.pwm_out), 1);

    // Duty requests change mid-period and apply only at the next period.
    p = NQ * 3;
    bus.FINAL_VALUE = 8'd2;
    bus.ciclo       = 9'd64;
    do_reset();
    @(posedge clk);
    count_window(p, 300, 128, hi);
    check("step_current_period", hi, 192);
    count_window(p, 400, 192, hi);
    check("step_period_128", hi, 384);
    count_window(p, -1, 0, hi);
    check("step_period_192", hi, 576);

    // Asynchronous reset while high, then a full restart checked by the model.
    bus.FINAL_VALUE = 8'd1;
    bus.ciclo       = 9'd256;
    do_reset();
    repeat (20) @(posedge clk);
    #1 check("pre_reset_high", int'(bus.pwm_out), 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check("async_reset_drop", int'(bus.pwm_out), 0);
    @(posedge clk);
    #1 check("reset_hold_low", int'(bus.pwm_out), 0);
    run_model(1, 64, 1100, 0, "restart");

    // Terminal count lowered from 194 to 10 while timer is at 100.
    bus.FINAL_VALUE = 8'd194;
    bus.ciclo       = 9'd3;
    do_reset();
    repeat (100) @(posedge clk);
    #1 bus.FINAL_VALUE = 8'd10;
    repeat (23) @(posedge clk);
    #1 check("fv_drop_q2_high", int'(bus.pwm_out), 1);
    @(posedge clk);
    #1 check("fv_drop_q3_low", int'(bus.pwm_out), 0);

    for (int r = 0; r < 6; r++) begin
      int fv, c;
      fv = $urandom_range(2, 0);
      c  = $urandom_range(300, 0);
      run_model(fv, c, 3 * NQ * (fv + 1) + 10, 150, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
